demux3_reg: RTL and testbench

- Registered 1-to-3 demultiplexer; the distribution-side counterpart of the 3-input datapath select muxes.
- Routes one input word to one of three output channels, chosen by a 3-bit selector with the same encoding the muxes use.
- Each output channel holds its word in a one-entry register, with a valid/ready handshake on every side.
- Sits between a producer (ALU result or memory data path) and up to three consumers (register-file write staging, PC staging, memory-data staging) so that consumers can stall independently.

---
 rtl/demux3_reg.sv | 78 +++++++
 tb/tb_demux3_reg.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux3_reg.sv
// demux3_reg: registered 1-to-3 demultiplexer. One producer feeds three
// one-entry holding registers, and each consumer drains its own channel
// independently through a valid/ready handshake.
module demux3_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       selector,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic [WIDTH-1:0] data_out_2,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic             sel_err,
  output logic [15:0]      xfer_count
);

  logic [2:0] target_hot;
  logic       illegal;
  logic       accept;
  logic [2:0] load;

  // Decode the selector to a one-hot target; unknown codes fall back to ch0
  always_comb begin
    target_hot = 3'b001;
    illegal    = 1'b0;
    case (selector)
      3'b000:  target_hot = 3'b001;
      3'b001:  target_hot = 3'b010;
      3'b010:  target_hot = 3'b100;
      default: illegal    = 1'b1;
    endcase
  end

  // Only the target channel matters: it must be empty or draining this cycle.
  // A drain and a reload on the same edge give one word per cycle per channel.
  assign in_ready = |(target_hot & (~out_valid | out_ready));
  assign accept   = in_valid && in_ready;
  assign load     = accept ? target_hot : 3'b000;

  // Valid flags: a load sets the flag, a drain without a reload clears it
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 3'b000;
    end else begin
      out_valid <= load | (out_valid & ~out_ready);
    end
  end

  // Channel data registers capture only on a load and hold after a drain
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out_0 <= '0;
      data_out_1 <= '0;
      data_out_2 <= '0;
    end else begin
      if (load[0]) data_out_0 <= data_in;
      if (load[1]) data_out_1 <= data_in;
      if (load[2]) data_out_2 <= data_in;
    end
  end

  // Transfer counter (wraps freely) and sticky illegal-selector flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      xfer_count <= 16'h0000;
      sel_err    <= 1'b0;
    end else if (accept) begin
      xfer_count <= xfer_count + 16'h0001;
      if (illegal) sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux3_reg.sv
// tb_demux3_reg: directed and randomized checks of demux3_reg against a
// behavioural per-channel model kept in the bench.
module tb_demux3_reg;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       selector;
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_out_0;
  logic [WIDTH-1:0] data_out_1;
  logic [WIDTH-1:0] data_out_2;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic             sel_err;
  logic [15:0]      xfer_count;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a one-slot mailbox holding its last word
  logic [WIDTH-1:0] m_data [3];
  logic             m_full [3];
  logic             m_err;
  logic [15:0]      m_count;

  demux3_reg #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .selector   (selector),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel_err    (sel_err),
    .xfer_count (xfer_count)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  function automatic int target_of(input logic [2:0] s);
    if (s == 3'd1) return 1;
    if (s == 3'd2) return 2;
    return 0;
  endfunction

  function automatic logic model_ready();
    int t;
    t = target_of(selector);
    return !m_full[t] || out_ready[t];
  endfunction

  function automatic logic [115:0] model_vec();
    return {m_full[2], m_full[1], m_full[0], m_err, m_count, m_data[2], m_data[1], m_data[0]};
  endfunction

  function automatic logic [115:0] dut_vec();
    return {out_valid, sel_err, xfer_count, data_out_2, data_out_1, data_out_0};
  endfunction

  function automatic logic [WIDTH-1:0] dut_chan(input int k);
    if (k == 1) return data_out_1;
    if (k == 2) return data_out_2;
    return data_out_0;
  endfunction

  // Advance one clock edge, then apply the same edge to the model using the
  // inputs that were held across it
  task automatic tick();
    logic acc;
    int   t;
    t   = target_of(selector);
    acc = in_valid && model_ready();
    @(posedge clk);
    #1;
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        m_data[k] = '0;
        m_full[k] = 1'b0;
      end
      m_err   = 1'b0;
      m_count = 16'h0000;
    end else begin
      for (int k = 0; k < 3; k++) if (out_ready[k]) m_full[k] = 1'b0;
      if (acc) begin
        m_data[t] = data_in;
        m_full[t] = 1'b1;
        m_count   = m_count + 16'h0001;
        if (selector > 3'd2) m_err = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b1;
    selector  = 3'b001;
    data_in   = 32'hCAFEF00D;
    out_ready = 3'b000;
    repeat (2) tick();
    checks++;
    if (dut_vec() !== 116'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected 0", dut_vec());
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_routing();
    logic [WIDTH-1:0] words [3];
    words[0]  = 32'h11111111;
    words[1]  = 32'h22222222;
    words[2]  = 32'h33333333;
    out_ready = 3'b111;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      selector = 3'(i);
      data_in  = words[i];
      tick();
      checks++;
      if (out_valid !== 3'(1 << i) || dut_chan(i) !== words[i]) begin
        errors++;
        $display("[TB] FAIL route_%0d: got valid %b data %h expected valid %b data %h",
                 i, out_valid, dut_chan(i), 3'(1 << i), words[i]);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL route_model_%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 3'b000 || xfer_count !== 16'd3 || sel_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL route_final: got valid %b count %0d err %b expected 000 3 0",
               out_valid, xfer_count, sel_err);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 3'b101;
    in_valid  = 1'b1;
    selector  = 3'b001;
    data_in   = 32'hAAAA0001;
    tick();
    data_in = 32'hAAAA0002;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_blocked: got in_ready %b expected 0", in_ready);
    end
    tick();
    checks++;
    if (data_out_1 !== 32'hAAAA0001 || out_valid[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_hold: got %h valid %b expected aaaa0001 valid 1", data_out_1, out_valid[1]);
    end
    selector = 3'b010;
    data_in  = 32'hBBBB0000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_other_ready: got in_ready %b expected 1", in_ready);
    end
    tick();
    checks++;
    if (data_out_2 !== 32'hBBBB0000 || out_valid !== 3'b110 || data_out_1 !== 32'hAAAA0001) begin
      errors++;
      $display("[TB] FAIL bp_other_accept: got ch2 %h valid %b ch1 %h expected bbbb0000 110 aaaa0001",
               data_out_2, out_valid, data_out_1);
    end
    selector  = 3'b001;
    data_in   = 32'hAAAA0002;
    out_ready = 3'b111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release_ready: got in_ready %b expected 1", in_ready);
    end
    tick();
    checks++;
    if (data_out_1 !== 32'hAAAA0002 || out_valid[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_reload: got %h valid %b expected aaaa0002 valid 1", data_out_1, out_valid[1]);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL bp_model: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_illegal();
    out_ready = 3'b000;
    in_valid  = 1'b1;
    selector  = 3'b111;
    data_in   = 32'hDEADBEEF;
    tick();
    checks++;
    if (data_out_0 !== 32'hDEADBEEF || out_valid[0] !== 1'b1 || sel_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_sel: got ch0 %h valid %b err %b expected deadbeef 1 1",
               data_out_0, out_valid[0], sel_err);
    end
    out_ready = 3'b111;
    selector  = 3'b001;
    data_in   = 32'h12345678;
    tick();
    in_valid = 1'b0;
    checks++;
    if (sel_err !== 1'b1 || data_out_1 !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL illegal_sticky: got err %b ch1 %h expected 1 12345678", sel_err, data_out_1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) selector = 3'($urandom_range(3, 7));
      else                           selector = 3'($urandom_range(0, 2));
      data_in   = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 3'($urandom);
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++;
        $display("[TB] FAIL rand_ready_%0d: got %b expected %b", i, in_ready, model_ready());
      end
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL rand_state_%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] expect_cnt [3];
    expect_cnt[0] = 16'hFFFF;
    expect_cnt[1] = 16'h0000;
    expect_cnt[2] = 16'h0001;
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    reset     = 1'b1;
    in_valid  = 1'b1;
    selector  = 3'b000;
    out_ready = 3'b111;
    for (int i = 0; i < 65534; i++) begin
      data_in = 32'(i);
      tick();
    end
    checks++;
    if (xfer_count !== 16'hFFFE || dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL wrap_preload: got count %h expected fffe", xfer_count);
    end
    for (int i = 0; i < 3; i++) begin
      data_in = 32'h5A5A0000 + 32'(i);
      tick();
      checks++;
      if (xfer_count !== expect_cnt[i]) begin
        errors++;
        $display("[TB] FAIL wrap_%0d: got count %h expected %h", i, xfer_count, expect_cnt[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    out_ready = 3'b000;
    in_valid  = 1'b1;
    selector  = 3'b010;
    data_in   = 32'h0C0C0C0C;
    tick();
    checks++;
    if (out_valid !== 3'b101) begin
      errors++;
      $display("[TB] FAIL midrst_setup: got valid %b expected 101", out_valid);
    end
    reset    = 1'b0;
    selector = 3'b001;
    data_in  = 32'h77777777;
    tick();
    checks++;
    if (dut_vec() !== 116'd0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got %h expected 0", dut_vec());
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    checks++;
    if (dut_vec() !== 116'd0 || dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL midrst_after: got %h expected 0", dut_vec());
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    for (int k = 0; k < 3; k++) begin
      m_data[k] = '0;
      m_full[k] = 1'b0;
    end
    m_err   = 1'b0;
    m_count = 16'h0000;
    test_reset();
    test_routing();
    test_backpressure();
    test_illegal();
    test_random();
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
